// File: rtl/pipe_stage_pkg.sv
// Shared constants and helpers for pipe_stage instances.
// Stage bundle widths and the fetch/decode NOP slot.
package pipe_stage_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_CTRL_W = 6;

    // Pointer width; a single-entry stage still needs a 1-bit index.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH register array for pipe_stage.
// One synchronous write port, one asynchronous read port.
module pipe_stage_mem
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int PW    = 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline stage: register (DEPTH=1), skid buffer (DEPTH>=2) or bypass.
// Define PIPE_STAGE_STATS_EN to add the saturating stall_count port.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 1,
    parameter int               BYPASS       = 0,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]                stall_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_w(DEPTH);

    if (BYPASS != 0) begin : g_bypass
        assign in_ready  = out_ready;
        assign out_valid = in_valid & ~flush;
        assign out_data  = in_data;
        assign occupancy = '0;
    end else begin : g_store
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] head;
        logic             has_room;
        logic             push;
        logic             pop;

        // Only the single register may look at out_ready; a skid buffer
        // must not carry a combinational ready path upstream.
        if (DEPTH == 1) begin : g_reg
            assign has_room = (count == '0) | out_ready;
        end else begin : g_skid
            assign has_room = count < CW'(DEPTH);
        end

        assign in_ready  = has_room & ~flush;
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;
        assign out_valid = count != '0;
        assign out_data  = out_valid ? head : BUBBLE_VALUE;
        assign occupancy = count;

        always_ff @(posedge clock) begin
            if (reset || flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end

        pipe_stage_mem #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH),
            .PW   (PW)
        ) u_mem (
            .clock(clock),
            .we   (push),
            .waddr(wr_ptr),
            .wdata(in_data),
            .raddr(rd_ptr),
            .rdata(head)
        );
    end

`ifdef PIPE_STAGE_STATS_EN
    // In bypass mode out_valid already equals in_valid & ~flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: register, skid, wrap, flush, bypass, stats.
// All instances share the input side; each test checks the instance it targets.
module tb_pipe_stage;
    import pipe_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy1, rdy2, rdy3, rdyb;
    logic        vld1, vld2, vld3, vldb;
    logic [31:0] dat1, dat2, dat3, datb;
    logic [0:0]  occ1, occb;
    logic [1:0]  occ2, occ3;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] st1, st2, st3, stb;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pipe_stage #(.WIDTH(32), .DEPTH(1), .BUBBLE_VALUE(INST_NOP)) u1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
        .occupancy(occ1)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_count(st1)
`endif
    );

    pipe_stage #(.WIDTH(32), .DEPTH(2), .BUBBLE_VALUE(INST_NOP)) u2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(vld2), .out_ready(out_ready), .out_data(dat2),
        .occupancy(occ2)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_count(st2)
`endif
    );

    pipe_stage #(.WIDTH(32), .DEPTH(3)) u3 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
        .out_valid(vld3), .out_ready(out_ready), .out_data(dat3),
        .occupancy(occ3)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_count(st3)
`endif
    );

    pipe_stage #(.WIDTH(32), .BYPASS(1)) ub (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdyb), .in_data(in_data),
        .out_valid(vldb), .out_ready(out_ready), .out_data(datb),
        .occupancy(occb)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_count(stb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] stream [3] = '{32'h11, 32'h22, 32'h33};

    initial begin
        // reset with in_valid held high
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        tick();
        #1;
        check("rst_vld", 32'(vld1), 32'd0);
        check("rst_dat", dat1, 32'h13);
        check("rst_occ", 32'(occ1), 32'd0);
        check("rst_occ2", 32'(occ2), 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_rdy1", 32'(rdy1), 32'd1);
        check("rst_rdy2", 32'(rdy2), 32'd1);

        // DEPTH=1 streaming at full throughput
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = stream[i];
            #1;
            check("s_rdy", 32'(rdy1), 32'd1);
            tick();
            check("s_dat", dat1, stream[i]);
            check("s_vld", 32'(vld1), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("s_empty_v", 32'(vld1), 32'd0);
        check("s_empty_d", dat1, 32'h13);

        // DEPTH=2 skid, DEPTH=1 back-pressure
        do_reset();
        in_valid = 1'b1;
        in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        tick();
        in_valid = 1'b0;
        #1;
        check("k_occ", 32'(occ2), 32'd2);
        check("k_rdy", 32'(rdy2), 32'd0);
        check("k_head", dat2, 32'hA1);
        check("r_hold", dat1, 32'hA1);
        check("r_rdy", 32'(rdy1), 32'd0);
        out_ready = 1'b1;
        #1;
        check("k_nocomb", 32'(rdy2), 32'd0);
        check("r_comb", 32'(rdy1), 32'd1);
        tick();
        check("k_pop1", dat2, 32'hA2);
        check("k_rdy1", 32'(rdy2), 32'd1);
        check("k_occ1", 32'(occ2), 32'd1);
        tick();
        check("k_pop2", 32'(vld2), 32'd0);

        // DEPTH=3 wrap with 1:1 push/pop after a 2-entry prefill
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h30 + 32'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 32'h32 + 32'(i);
            #1;
            check("w_dat", dat3, 32'h30 + 32'(i));
            check("w_occ", 32'(occ3), 32'd2);
            tick();
        end
        in_valid = 1'b0;
        check("w_tail0", dat3, 32'h37);
        tick();
        check("w_tail1", dat3, 32'h38);
        tick();
        check("w_drain", 32'(vld3), 32'd0);

        // flush while full
        do_reset();
        in_valid = 1'b1;
        in_data = 32'hB1;
        tick();
        in_data = 32'hB2;
        tick();
        in_data = 32'hB3;
        flush = 1'b1;
        #1;
        check("f_rdy", 32'(rdy2), 32'd0);
        check("f_vld", 32'(vld2), 32'd1);
        check("f_dat", dat2, 32'hB1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("f_occ", 32'(occ2), 32'd0);
        check("f_bub", dat2, 32'h13);
        check("f_vld2", 32'(vld2), 32'd0);

        // bypass
        do_reset();
        in_valid = 1'b1;
        in_data = 32'h55;
        #1;
        check("b_vld", 32'(vldb), 32'd1);
        check("b_dat", datb, 32'h55);
        check("b_rdy0", 32'(rdyb), 32'd0);
        check("b_occ", 32'(occb), 32'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("b_rdy1", 32'(rdyb), 32'd1);
        check("b_flush", 32'(vldb), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
        do_reset();
        in_valid = 1'b1;
        in_data = 32'hC1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("st_5", st2, 32'd5);
        check("st_b", stb, 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        check("st_fl", st2, 32'd5);
        check("st_flocc", 32'(occ2), 32'd0);
        do_reset();
        #1;
        check("st_rst", st2, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
